vga_pattern_engine: RTL
=======================

VGA_PATTERN_ENGINE -- requirements
Module: vga_pattern_engine

Interface
REQ-001 SHALL provide parameter H_CENTER, 320, horizontal pattern centre in pixels.
REQ-002 SHALL provide parameter V_CENTER, 240, vertical pattern centre in lines.
REQ-003 SHALL provide parameter POS_W, 10, width of hpos/vpos.
REQ-004 SHALL provide parameter RADIUS_W, 8 (legal 6..POS_W), width of the animated metric.
REQ-005 SHALL provide parameter FRAME_W, 10 (legal >= RADIUS_W), width of the frame counter.
REQ-006 SHALL provide ports clk input 1 (single clock, all logic on rising edge) and reset input 1 (synchronous, active-high).
REQ-007 SHALL provide inputs hpos POS_W, vpos POS_W, display_on 1, hsync_in 1 and vsync_in 1, all from the external sync generator.
REQ-008 SHALL provide control inputs speed 2 (step select), direction 1 (0 = outward, 1 = inward), pause 1 (freeze animation) and mode 2 (pattern select).
REQ-009 SHALL provide outputs r 2, g 2, b 2 (RGB222), hsync_out 1, vsync_out 1 and frame_count FRAME_W.

Function
REQ-010 A frame-start event SHALL be the cycle in which hpos==0 and vpos==0.
REQ-011 On frame start, frame_count SHALL add step = 1<<speed (1/2/4/8) modulo 2^FRAME_W, using the live speed and pause values; with pause=1 it SHALL hold.
REQ-012 On frame start, direction and mode SHALL be latched into shadow registers; mid-frame changes SHALL have no effect until the next frame start.
REQ-013 The pipeline SHALL have two stages, so r/g/b, hsync_out and vsync_out correspond to inputs presented exactly 2 cycles earlier; syncs and display_on SHALL be delayed in step with pixel data.
REQ-014 Stage 1 SHALL register dx=|hpos-H_CENTER| and dy=|vpos-V_CENTER|, computed signed at POS_W+1 bits.
REQ-015 Stage 2 metric m (POS_W+1 bits) SHALL be selected by latched mode: 0 = max(dx,dy)+(min(dx,dy)>>1), 1 = max(dx,dy), 2 = dx+dy, 3 = dx XOR dy.
REQ-016 anim SHALL equal m[RADIUS_W-1:0] plus (direction 0) or minus (direction 1) the offset frame_count[RADIUS_W-2:0]<<1, modulo 2^RADIUS_W.
REQ-017 r SHALL equal anim[RADIUS_W-3:RADIUS_W-4], g SHALL equal anim[RADIUS_W-2:RADIUS_W-3], and b SHALL equal anim[RADIUS_W-1:RADIUS_W-2].
REQ-018 r/g/b SHALL be 0 whenever the delayed display_on is 0.
REQ-019 frame_count SHALL be the live counter value; the counter value sampled at the stage-1 cycle SHALL be the one used for that pixel.

Reset
REQ-020 With reset high at a clock edge, all registers SHALL clear: r=g=b=0, hsync_out=0, vsync_out=0, frame_count=0, shadow direction=0, shadow mode=0, pipeline valid data=0.
REQ-021 Reset SHALL override a coincident frame-start event; the first increment SHALL occur at the first frame start after reset deasserts.
REQ-022 Reset asserted mid-frame SHALL discard in-flight pipeline contents; outputs SHALL be 0 for 2 cycles after reset deasserts.

Configuration
REQ-023 Macro VGA_PATTERN_DITHER_EN, when defined, SHALL add to each colour channel (saturating at 3) the bit anim[RADIUS_W-5] AND (hpos[0] XOR vpos[0]), using the pixel's stage-1 position; blanking (REQ-018) still applies.
REQ-024 Without VGA_PATTERN_DITHER_EN, colours SHALL be exactly as in REQ-017, and no dither logic SHALL be synthesised.

Verification (defaults, macro undefined unless noted)
REQ-025 Stimulus: reset high 3 cycles with random inputs -> required response: all outputs 0 and frame_count 0, and outputs stay 0 for 2 cycles after release.
REQ-026 Stimulus: hsync_in pulse at cycle N, display_on=0 -> required response: hsync_out pulse at N+2 with identical width, and r=g=b=0 throughout.
REQ-027 Stimulus: speed=2, pause=0, 3 frame starts -> required response: frame_count=12; then pause=1 with 2 frame starts -> frame_count stays 12; then frame_count=1023 with speed=0 and 1 frame start -> frame_count=0.
REQ-028 Stimulus: mode=0, direction=1 latched, frame_count=3, pixel (321,240), display_on=1 -> required response: anim=251, and r=3, g=3, b=3 two cycles later.
REQ-029 Stimulus: pixel (330,250), frame_count=0, direction=0 -> required response: mode 2 gives m=20, r=1, g=0, b=0; mode 0 gives m=15, r=0, g=0, b=0.
REQ-030 Stimulus: mode changes 0->2 mid-frame -> required response: output keeps mode-0 colours until 2 cycles after the next frame start; with VGA_PATTERN_DITHER_EN defined, pixel (331,240), mode 0, frame_count 0 -> m=11, r=1.

Source files
------------

// File: rtl/vga_pattern_engine.sv
// rtl/vga_pattern_engine.sv - animated radial pattern generator on an external VGA sync stream
// Optional: define VGA_PATTERN_DITHER_EN to add a position-parity dither to each colour channel.
module vga_pattern_engine #(
  parameter int H_CENTER = 320,
  parameter int V_CENTER = 240,
  parameter int POS_W    = 10,
  parameter int RADIUS_W = 8,
  parameter int FRAME_W  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [POS_W-1:0]   hpos,
  input  logic [POS_W-1:0]   vpos,
  input  logic               display_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [1:0]         speed,
  input  logic               direction,
  input  logic               pause,
  input  logic [1:0]         mode,
  output logic [1:0]         r,
  output logic [1:0]         g,
  output logic [1:0]         b,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int SW = POS_W + 1;
`ifdef VGA_PATTERN_DITHER_EN
  localparam int TOP = 5;
`else
  localparam int TOP = 4;
`endif

  logic             frame_start;
  logic [SW-1:0]    hdiff, vdiff, dx, dy;

  logic [SW-1:0]       dx_s1, dy_s1;
  logic [RADIUS_W-2:0] fc_s1;
  logic                de_s1, hs_s1, vs_s1;
  logic                dir_q;
  logic [1:0]          mode_q;
`ifdef VGA_PATTERN_DITHER_EN
  logic                par_s1;
`endif

  logic                ge;
  logic [RADIUS_W-1:0] mx_lo, mn_half, m_lo, offset;
  logic [TOP-1:0]      anim_top;
  logic [1:0]          r_c, g_c, b_c;

  assign frame_start = (hpos == '0) && (vpos == '0);
  assign hdiff = {1'b0, hpos} - SW'(H_CENTER);
  assign vdiff = {1'b0, vpos} - SW'(V_CENTER);
  assign dx = hdiff[SW-1] ? (~hdiff + SW'(1)) : hdiff;
  assign dy = vdiff[SW-1] ? (~vdiff + SW'(1)) : vdiff;

  // Only the low RADIUS_W bits of the metric reach the colour stage.
  assign ge      = (dx_s1 >= dy_s1);
  assign mx_lo   = ge ? dx_s1[RADIUS_W-1:0] : dy_s1[RADIUS_W-1:0];
  assign mn_half = ge ? dy_s1[RADIUS_W:1]   : dx_s1[RADIUS_W:1];
  assign offset  = {fc_s1, 1'b0};

  always_comb begin
    m_lo = '0;
    case (mode_q)
      2'd0: m_lo = mx_lo + mn_half;
      2'd1: m_lo = mx_lo;
      2'd2: m_lo = dx_s1[RADIUS_W-1:0] + dy_s1[RADIUS_W-1:0];
      default: m_lo = dx_s1[RADIUS_W-1:0] ^ dy_s1[RADIUS_W-1:0];
    endcase
  end

  // The concatenation pins the sum to RADIUS_W bits so it wraps before the shift.
  assign anim_top = TOP'({dir_q ? (m_lo - offset) : (m_lo + offset)} >> (RADIUS_W - TOP));

`ifdef VGA_PATTERN_DITHER_EN
  function automatic logic [1:0] sat_inc(input logic [1:0] c, input logic d);
    return (c == 2'd3) ? c : c + {1'b0, d};
  endfunction

  always_comb begin
    r_c = sat_inc(anim_top[TOP-3:TOP-4], anim_top[0] & par_s1);
    g_c = sat_inc(anim_top[TOP-2:TOP-3], anim_top[0] & par_s1);
    b_c = sat_inc(anim_top[TOP-1:TOP-2], anim_top[0] & par_s1);
  end
`else
  always_comb begin
    r_c = anim_top[TOP-3:TOP-4];
    g_c = anim_top[TOP-2:TOP-3];
    b_c = anim_top[TOP-1:TOP-2];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      dir_q       <= 1'b0;
      mode_q      <= 2'd0;
      dx_s1       <= '0;
      dy_s1       <= '0;
      fc_s1       <= '0;
      de_s1       <= 1'b0;
      hs_s1       <= 1'b0;
      vs_s1       <= 1'b0;
`ifdef VGA_PATTERN_DITHER_EN
      par_s1      <= 1'b0;
`endif
      r           <= 2'd0;
      g           <= 2'd0;
      b           <= 2'd0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
    end else begin
      if (frame_start) begin
        dir_q  <= direction;
        mode_q <= mode;
        if (!pause)
          frame_count <= frame_count + (FRAME_W'(1) << speed);
      end
      dx_s1 <= dx;
      dy_s1 <= dy;
      fc_s1 <= frame_count[RADIUS_W-2:0];
      de_s1 <= display_on;
      hs_s1 <= hsync_in;
      vs_s1 <= vsync_in;
`ifdef VGA_PATTERN_DITHER_EN
      par_s1 <= hpos[0] ^ vpos[0];
`endif
      hsync_out <= hs_s1;
      vsync_out <= vs_s1;
      r <= de_s1 ? r_c : 2'd0;
      g <= de_s1 ? g_c : 2'd0;
      b <= de_s1 ? b_c : 2'd0;
    end
  end

endmodule
